// File: rtl/zmod_rx_aligner.sv
// Receive word aligner for the zmod LVDS link: finds the sync-lane bit rotation,
// applies it to every lane, and tracks lock through HUNT/VERIFY/LOCKED.
module zmod_rx_aligner #(
    parameter int                LANES        = 4,
    parameter int                WIDTH        = 8,
    parameter int                SYNC_LANE    = LANES - 1,
    parameter logic [WIDTH-1:0]  SYNC_WORD    = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter int                LOCK_COUNT   = 16,
    parameter int                UNLOCK_COUNT = 4,
    parameter int                ERR_W        = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [LANES*WIDTH-1:0]     rx_data,
    input  logic                       rx_valid,
    output logic [LANES*WIDTH-1:0]     out_data,
    output logic                       out_valid,
    output logic                       locked,
    output logic [$clog2(WIDTH)-1:0]   shift,
    output logic                       lock_lost,
    output logic [ERR_W-1:0]           err_count
);

    localparam int SW = $clog2(WIDTH);
    localparam int CW = $clog2(LOCK_COUNT + 1);
    localparam int MW = $clog2(UNLOCK_COUNT + 1);

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    state_t                   state_q, state_d;
    logic [SW-1:0]            shift_q, shift_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [MW-1:0]            miss_q, miss_d;
    logic [ERR_W-1:0]         err_q, err_d;
    logic                     lost_d;
    logic [LANES*WIDTH-1:0]   prev_q;
    logic [LANES*WIDTH-1:0]   aligned;
    logic [2*WIDTH-1:0]       sync_win;
    logic [WIDTH-1:0]         hit;
    logic [SW-1:0]            best;
    logic                     any_hit;
    logic                     good;

    // Every candidate rotation of the sync lane is compared in parallel.
    always_comb begin
        sync_win = {prev_q[SYNC_LANE*WIDTH +: WIDTH], rx_data[SYNC_LANE*WIDTH +: WIDTH]};
        hit      = '0;
        for (int s = 0; s < WIDTH; s++) begin
            hit[s] = (sync_win[s +: WIDTH] == SYNC_WORD);
        end
        best = '0;
        for (int s = WIDTH - 1; s >= 0; s--) begin
            if (hit[s]) begin
                best = SW'(s);
            end
        end
        any_hit = |hit;
        good    = hit[shift_q];
    end

    always_comb begin
        logic [2*WIDTH-1:0] win;
        win     = '0;
        aligned = '0;
        for (int i = 0; i < LANES; i++) begin
            win = {prev_q[i*WIDTH +: WIDTH], rx_data[i*WIDTH +: WIDTH]} >> shift_q;
            aligned[i*WIDTH +: WIDTH] = win[WIDTH-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        miss_d  = miss_q;
        err_d   = err_q;
        lost_d  = 1'b0;
        if (rx_valid) begin
            case (state_q)
                HUNT: begin
                    if (any_hit) begin
                        shift_d = best;
                        cnt_d   = CW'(1);
                        state_d = (LOCK_COUNT == 1) ? LOCKED : VERIFY;
                    end
                end
                VERIFY: begin
                    // A miss here discards the word; capture resumes on the next one.
                    if (good) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_d == CW'(LOCK_COUNT)) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        state_d = HUNT;
                    end
                end
                LOCKED: begin
                    if (good) begin
                        miss_d = '0;
                    end else begin
                        if (err_q != '1) begin
                            err_d = err_q + 1'b1;
                        end
                        if (miss_q + 1'b1 == MW'(UNLOCK_COUNT)) begin
                            state_d = HUNT;
                            lost_d  = 1'b1;
                            miss_d  = '0;
                        end else begin
                            miss_d = miss_q + 1'b1;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= HUNT;
            shift_q   <= '0;
            cnt_q     <= '0;
            miss_q    <= '0;
            err_q     <= '0;
            prev_q    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            lock_lost <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            miss_q    <= miss_d;
            err_q     <= err_d;
            lock_lost <= lost_d;
            out_valid <= rx_valid && (state_q == LOCKED);
            if (rx_valid) begin
                prev_q   <= rx_data;
                out_data <= aligned;
            end
        end
    end

    assign locked    = (state_q == LOCKED);
    assign shift     = shift_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_zmod_rx_aligner.sv
// Directed bench for zmod_rx_aligner: LANES=4, WIDTH=8, sync 0x01, LOCK_COUNT=4, UNLOCK_COUNT=3.
module tb_zmod_rx_aligner;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic [31:0] out_data;
    logic        out_valid;
    logic        locked;
    logic [2:0]  shift;
    logic        lock_lost;
    logic [15:0] err_count;

    int          total = 0;
    int          bad   = 0;
    logic [23:0] cnt;
    logic [31:0] a_prev, a_cur;

    zmod_rx_aligner #(
        .LANES(4), .WIDTH(8), .SYNC_LANE(3), .SYNC_WORD(8'h01),
        .LOCK_COUNT(4), .UNLOCK_COUNT(3), .ERR_W(16)
    ) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .out_data(out_data), .out_valid(out_valid), .locked(locked),
        .shift(shift), .lock_lost(lock_lost), .err_count(err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] mk(input logic [7:0] sync, input logic [23:0] c);
        return {sync, c[23:16], c[15:8], c[7:0]};
    endfunction

    // Each lane's bitstream delayed so that rotation 3 recovers the previous aligned word.
    function automatic logic [31:0] dly(input logic [31:0] p, input logic [31:0] a);
        logic [15:0] w;
        logic [31:0] d;
        d = '0;
        for (int l = 0; l < 4; l++) begin
            w = {p[l*8 +: 8], a[l*8 +: 8]} >> 5;
            d[l*8 +: 8] = w[7:0];
        end
        return d;
    endfunction

    task automatic applyStimulus(input logic [31:0] data, input logic valid);
        rx_data  = data;
        rx_valid = valid;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_data = '0;
        @(posedge clk); #1;

        // Reset dominates a valid word.
        applyStimulus(32'hDEAD_BEEF, 1'b1);
        rst = 1'b0;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_locked",    32'(locked),    32'd0);
        checkOutput("rst_shift",     32'(shift),     32'd0);
        checkOutput("rst_lock_lost", 32'(lock_lost), 32'd0);
        checkOutput("rst_err",       32'(err_count), 32'd0);
        checkOutput("rst_out_data",  out_data,       32'd0);

        // Aligned stream locks at shift 0 after four valid words.
        cnt = 24'h000100;
        applyStimulus(mk(8'h01, cnt), 1'b1); cnt++;
        applyStimulus(mk(8'h01, cnt), 1'b1); cnt++;
        applyStimulus(mk(8'h01, cnt), 1'b1); cnt++;
        checkOutput("t1_locked_3", 32'(locked), 32'd0);
        applyStimulus(mk(8'h01, cnt), 1'b1); cnt++;
        checkOutput("t1_locked_4", 32'(locked),    32'd1);
        checkOutput("t1_shift",    32'(shift),     32'd0);
        checkOutput("t1_ovalid_4", 32'(out_valid), 32'd0);
        a_cur = mk(8'h01, cnt);
        applyStimulus(a_cur, 1'b1); cnt++;
        checkOutput("t1_ovalid_5", 32'(out_valid), 32'd1);
        checkOutput("t1_out_data", out_data,       a_cur);
        checkOutput("t1_err",      32'(err_count), 32'd0);

        // Two misses then a good word: lock held.
        applyStimulus(mk(8'h00, cnt), 1'b1); cnt++;
        checkOutput("t4_err_1", 32'(err_count), 32'd1);
        applyStimulus(mk(8'h00, cnt), 1'b1); cnt++;
        applyStimulus(mk(8'h01, cnt), 1'b1); cnt++;
        checkOutput("t4_locked_hold", 32'(locked),    32'd1);
        checkOutput("t4_err_2",       32'(err_count), 32'd2);
        // Three consecutive misses drop lock.
        applyStimulus(mk(8'h00, cnt), 1'b1); cnt++;
        applyStimulus(mk(8'h00, cnt), 1'b1); cnt++;
        checkOutput("t4_lost_early", 32'(lock_lost), 32'd0);
        checkOutput("t4_locked_mid", 32'(locked),    32'd1);
        applyStimulus(mk(8'h00, cnt), 1'b1); cnt++;
        checkOutput("t4_lost_pulse", 32'(lock_lost), 32'd1);
        checkOutput("t4_unlocked",   32'(locked),    32'd0);
        checkOutput("t4_err_5",      32'(err_count), 32'd5);
        applyStimulus(mk(8'h01, cnt), 1'b1); cnt++;
        checkOutput("t4_lost_clear", 32'(lock_lost), 32'd0);
        applyStimulus(mk(8'h01, cnt), 1'b1); cnt++;
        applyStimulus(mk(8'h01, cnt), 1'b1); cnt++;
        checkOutput("t4_relock_3", 32'(locked), 32'd0);
        applyStimulus(mk(8'h01, cnt), 1'b1); cnt++;
        checkOutput("t4_relock_4", 32'(locked),    32'd1);
        checkOutput("t4_err_keep", 32'(err_count), 32'd5);

        // Reset while locked clears everything, including the error count.
        rst = 1'b1;
        applyStimulus(mk(8'h01, cnt), 1'b1); cnt++;
        rst = 1'b0;
        checkOutput("t6_err",      32'(err_count), 32'd0);
        checkOutput("t6_locked",   32'(locked),    32'd0);
        checkOutput("t6_ovalid",   32'(out_valid), 32'd0);
        checkOutput("t6_out_data", out_data,       32'd0);
        applyStimulus(mk(8'h01, cnt), 1'b1); cnt++;
        applyStimulus(mk(8'h01, cnt), 1'b1); cnt++;
        applyStimulus(mk(8'h01, cnt), 1'b1); cnt++;
        checkOutput("t6_relock_3", 32'(locked), 32'd0);
        applyStimulus(mk(8'h01, cnt), 1'b1); cnt++;
        checkOutput("t6_relock_4", 32'(locked), 32'd1);

        // Gapped valid: lock still counts valid words only; outputs hold in gaps.
        rst = 1'b1;
        applyStimulus(32'h0, 1'b0);
        rst = 1'b0;
        cnt = 24'h005000;
        applyStimulus(mk(8'h01, cnt), 1'b1); cnt++;
        applyStimulus(32'hFFFF_FFFF, 1'b0);
        applyStimulus(mk(8'h01, cnt), 1'b1); cnt++;
        applyStimulus(mk(8'h01, cnt), 1'b1); cnt++;
        checkOutput("t3_locked_3", 32'(locked), 32'd0);
        applyStimulus(32'hFFFF_FFFF, 1'b0);
        applyStimulus(32'h5A5A_5A5A, 1'b0);
        checkOutput("t3_gap_ovalid", 32'(out_valid), 32'd0);
        a_cur = mk(8'h01, cnt);
        applyStimulus(a_cur, 1'b1); cnt++;
        checkOutput("t3_locked_4", 32'(locked), 32'd1);
        applyStimulus(32'hFFFF_FFFF, 1'b0);
        checkOutput("t3_gap_ovalid2", 32'(out_valid), 32'd0);
        checkOutput("t3_gap_hold",    out_data,       a_cur);
        checkOutput("t3_gap_locked",  32'(locked),    32'd1);
        a_cur = mk(8'h01, cnt);
        applyStimulus(a_cur, 1'b1); cnt++;
        checkOutput("t3_ovalid_5",   32'(out_valid), 32'd1);
        checkOutput("t3_out_data_5", out_data,       a_cur);

        // Every lane delayed: rotation 3 recovers the words one cycle late.
        rst = 1'b1;
        applyStimulus(32'h0, 1'b0);
        rst = 1'b0;
        cnt    = 24'h00A000;
        a_prev = mk(8'h01, cnt - 24'd1);
        for (int k = 0; k < 4; k++) begin
            a_cur = mk(8'h01, cnt + 24'(k));
            applyStimulus(dly(a_prev, a_cur), 1'b1);
            a_prev = a_cur;
            if (k == 0) checkOutput("t2_shift_capture", 32'(shift), 32'd3);
            if (k == 2) checkOutput("t2_locked_3", 32'(locked), 32'd0);
        end
        checkOutput("t2_locked_4", 32'(locked), 32'd1);
        checkOutput("t2_shift",    32'(shift),  32'd3);
        a_cur = mk(8'h01, cnt + 24'd4);
        applyStimulus(dly(a_prev, a_cur), 1'b1);
        a_prev = a_cur;
        checkOutput("t2_ovalid",  32'(out_valid), 32'd1);
        checkOutput("t2_out_a3",  out_data,       mk(8'h01, cnt + 24'd3));
        a_cur = mk(8'h01, cnt + 24'd5);
        applyStimulus(dly(a_prev, a_cur), 1'b1);
        a_prev = a_cur;
        checkOutput("t2_out_a4",  out_data,       mk(8'h01, cnt + 24'd4));
        rst = 1'b1;
        applyStimulus(dly(a_prev, mk(8'h01, cnt + 24'd6)), 1'b1);
        rst = 1'b0;
        checkOutput("t2_rst_shift",  32'(shift),  32'd0);
        checkOutput("t2_rst_locked", 32'(locked), 32'd0);

        // Verify interrupted by a shift-5 stream; it is re-captured on the following word.
        rst = 1'b1;
        applyStimulus(32'h0, 1'b0);
        rst = 1'b0;
        applyStimulus(32'h0800_0000, 1'b1);
        checkOutput("t5_shift3", 32'(shift), 32'd3);
        applyStimulus(32'h0800_0000, 1'b1);
        checkOutput("t5_verify_locked", 32'(locked), 32'd0);
        applyStimulus(32'h2000_0000, 1'b1);
        checkOutput("t5_bad_shift_held", 32'(shift),  32'd3);
        checkOutput("t5_bad_locked",     32'(locked), 32'd0);
        applyStimulus(32'h2000_0000, 1'b1);
        checkOutput("t5_shift5", 32'(shift), 32'd5);
        applyStimulus(32'h2000_0000, 1'b1);
        applyStimulus(32'h2000_0000, 1'b1);
        checkOutput("t5_locked_3", 32'(locked), 32'd0);
        applyStimulus(32'h2000_0000, 1'b1);
        checkOutput("t5_locked_4", 32'(locked), 32'd1);
        applyStimulus(32'h2000_0000, 1'b1);
        checkOutput("t5_ovalid",   32'(out_valid), 32'd1);
        checkOutput("t5_out_data", out_data,       32'h0100_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
